// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next-PC source, drives pipeline bubble/flush
// controls and the imem fetch handshake. Optional macro DELAY_SLOT_EN keeps branch/jump delay slots.
module pc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_branch_taken,
  input  logic       i_jump,
  input  logic       i_jump_reg,
  input  logic       i_stall,
  input  logic       i_imem_ready,
  output logic       o_imem_req,
  output logic [1:0] o_pc_sel,
  output logic       o_pc_we,
  output logic       o_ifid_we,
  output logic       o_flush_ifid,
  output logic       o_flush_idex
);

  localparam int unsigned PC_SEL_W = 2;

  localparam logic [PC_SEL_W-1:0] SEL_SEQ = 2'b00;
  localparam logic [PC_SEL_W-1:0] SEL_BR  = 2'b01;
  localparam logic [PC_SEL_W-1:0] SEL_JMP = 2'b10;
  localparam logic [PC_SEL_W-1:0] SEL_JR  = 2'b11;

`ifdef DELAY_SLOT_EN
  localparam logic BR_FLUSH_IDEX  = 1'b0;
  localparam logic JMP_FLUSH_IFID = 1'b0;
`else
  localparam logic BR_FLUSH_IDEX  = 1'b1;
  localparam logic JMP_FLUSH_IFID = 1'b1;
`endif

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_jump_any;
  logic w_hold;

  // A jump that cannot fetch its target yet behaves like a load-use stall.
  assign w_jump_any = i_jump | i_jump_reg;
  assign w_hold     = i_stall | (w_jump_any & ~i_imem_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: only a taken branch over a pending fetch needs an abort cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:  w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (i_branch_taken && !i_imem_ready) begin
          w_state_nxt = ST_ABORT;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_ABORT: w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_BOOT;
    endcase
  end

  // Mealy output decode, priority ladder in FETCH
  always_comb begin
    o_imem_req   = 1'b0;
    o_pc_sel     = SEL_SEQ;
    o_pc_we      = 1'b0;
    o_ifid_we    = 1'b0;
    o_flush_ifid = 1'b0;
    o_flush_idex = 1'b0;
    case (r_state)
      ST_BOOT: begin
        o_ifid_we    = 1'b1;
        o_flush_ifid = 1'b1;
        o_flush_idex = 1'b1;
      end
      ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_branch_taken) begin
          o_pc_sel     = SEL_BR;
          o_pc_we      = 1'b1;
          o_ifid_we    = 1'b1;
          o_flush_ifid = 1'b1;
          o_flush_idex = BR_FLUSH_IDEX;
        end else if (w_hold) begin
          o_flush_idex = 1'b1;
        end else if (w_jump_any) begin
          o_pc_sel     = i_jump_reg ? SEL_JR : SEL_JMP;
          o_pc_we      = 1'b1;
          o_ifid_we    = 1'b1;
          o_flush_ifid = JMP_FLUSH_IFID;
        end else if (!i_imem_ready) begin
          o_ifid_we    = 1'b1;
          o_flush_ifid = 1'b1;
        end else begin
          o_pc_sel  = SEL_SEQ;
          o_pc_we   = 1'b1;
          o_ifid_we = 1'b1;
        end
      end
      ST_ABORT: begin
        o_ifid_we    = 1'b1;
        o_flush_ifid = 1'b1;
      end
      default: begin
        o_ifid_we    = 1'b1;
        o_flush_ifid = 1'b1;
        o_flush_idex = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed literal checks plus random stimulus
// compared every cycle against a behavioural model.
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       branch_taken, jump, jump_reg, stall, imem_ready;
  logic       imem_req;
  logic [1:0] pc_sel;
  logic       pc_we, ifid_we, flush_ifid, flush_idex;

  int n_checks;
  int n_pass;

`ifdef DELAY_SLOT_EN
  localparam logic FX_BR = 1'b0;
  localparam logic FI_J  = 1'b0;
`else
  localparam logic FX_BR = 1'b1;
  localparam logic FI_J  = 1'b1;
`endif

  // model phases: 0 = just reset, 1 = running, 2 = killing a stale fetch
  int m_phase;

  pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_branch_taken (branch_taken),
    .i_jump         (jump),
    .i_jump_reg     (jump_reg),
    .i_stall        (stall),
    .i_imem_ready   (imem_ready),
    .o_imem_req     (imem_req),
    .o_pc_sel       (pc_sel),
    .o_pc_we        (pc_we),
    .o_ifid_we      (ifid_we),
    .o_flush_ifid   (flush_ifid),
    .o_flush_idex   (flush_idex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {imem_req, pc_sel, pc_we, ifid_we, flush_ifid, flush_idex}
  function automatic logic [6:0] pack(input logic rq, input logic [1:0] sel, input logic pw,
                                      input logic iw, input logic fi, input logic fx);
    return {rq, sel, pw, iw, fi, fx};
  endfunction

  function automatic logic [6:0] model_out(input int ph, input logic bt, input logic j,
                                           input logic jr, input logic st, input logic rdy);
    if (ph == 0) return pack(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
    if (ph == 2) return pack(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    if (bt)                  return pack(1'b1, 2'b01, 1'b1, 1'b1, 1'b1, FX_BR);
    if (st)                  return pack(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    if ((j || jr) && !rdy)   return pack(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    if (jr)                  return pack(1'b1, 2'b11, 1'b1, 1'b1, FI_J, 1'b0);
    if (j)                   return pack(1'b1, 2'b10, 1'b1, 1'b1, FI_J, 1'b0);
    if (!rdy)                return pack(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    return pack(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [6:0] dut_out();
    return pack(imem_req, pc_sel, pc_we, ifid_we, flush_ifid, flush_idex);
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (req,sel,pc_we,ifid_we,fl_ifid,fl_idex)",
                  name, got, exp);
  endtask

  // Behavioural phase tracking
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_phase = 0;
    else if (m_phase == 1 && branch_taken && !imem_ready) m_phase = 2;
    else m_phase = 1;
  end

  // Per-cycle compare against the model, mid low phase
  always @(negedge clk) begin
    #4;
    check("model", dut_out(),
          model_out(m_phase, branch_taken, jump, jump_reg, stall, imem_ready));
  end

  task automatic drive(input logic bt, input logic j, input logic jr, input logic st,
                       input logic rdy);
    @(negedge clk);
    branch_taken = bt; jump = j; jump_reg = jr; stall = st; imem_ready = rdy;
    #1;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; m_phase = 0;
    rst_n = 1'b0;
    branch_taken = 0; jump = 0; jump_reg = 0; stall = 0; imem_ready = 1;

    // reset held, then first cycle after release is BOOT
    drive(0, 0, 0, 0, 1);
    check("in_reset", dut_out(), 7'b0_00_0111);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    rst_n = 1'b1;
    check("boot", dut_out(), 7'b0_00_0111);
    drive(0, 0, 0, 0, 1);
    check("seq1", dut_out(), 7'b1_00_1100);
    drive(0, 0, 0, 0, 1);
    check("seq2", dut_out(), 7'b1_00_1100);

    // taken branch with memory ready: no abort
    drive(1, 0, 0, 0, 1);
    check("br_rdy", dut_out(), {1'b1, 2'b01, 1'b1, 1'b1, 1'b1, FX_BR});
    drive(0, 0, 0, 0, 1);
    check("br_rdy_next", dut_out(), 7'b1_00_1100);

    // taken branch in a wait state: one abort cycle then request again
    drive(1, 0, 0, 0, 0);
    check("br_wait", dut_out(), {1'b1, 2'b01, 1'b1, 1'b1, 1'b1, FX_BR});
    drive(0, 0, 0, 0, 1);
    check("abort", dut_out(), 7'b0_00_0110);
    drive(0, 0, 0, 0, 1);
    check("after_abort", dut_out(), 7'b1_00_1100);

    // stall with branch: branch wins, then stall alone
    drive(1, 0, 0, 1, 1);
    check("stall_br", dut_out(), {1'b1, 2'b01, 1'b1, 1'b1, 1'b1, FX_BR});
    drive(0, 0, 0, 1, 1);
    check("stall", dut_out(), 7'b1_00_0001);

    // jr waiting on memory
    drive(0, 0, 1, 0, 0);
    check("jr_wait1", dut_out(), 7'b1_00_0001);
    drive(0, 0, 1, 0, 0);
    check("jr_wait2", dut_out(), 7'b1_00_0001);
    drive(0, 0, 1, 0, 1);
    check("jr_go", dut_out(), {1'b1, 2'b11, 1'b1, 1'b1, FI_J, 1'b0});
    drive(0, 1, 0, 0, 1);
    check("jump", dut_out(), {1'b1, 2'b10, 1'b1, 1'b1, FI_J, 1'b0});
    drive(0, 1, 1, 0, 1);
    check("j_and_jr", dut_out(), {1'b1, 2'b11, 1'b1, 1'b1, FI_J, 1'b0});
    drive(0, 0, 0, 0, 0);
    check("imem_wait", dut_out(), 7'b1_00_0110);

    // reset asserted during ABORT takes effect immediately
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("abort2", dut_out(), 7'b0_00_0110);
    #1 rst_n = 1'b0;
    #1 check("rst_in_abort", dut_out(), 7'b0_00_0111);
    drive(0, 0, 0, 0, 1);
    rst_n = 1'b1;
    check("boot2", dut_out(), 7'b0_00_0111);
    drive(0, 0, 0, 0, 1);
    check("fetch2", dut_out(), 7'b1_00_1100);

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(199) == 0) rst_n = 1'b0;
      branch_taken = ($urandom_range(5) == 0);
      jump         = ($urandom_range(4) == 0);
      jump_reg     = ($urandom_range(4) == 0);
      stall        = ($urandom_range(5) == 0);
      imem_ready   = ($urandom_range(2) != 0);
    end
    @(negedge clk);
    #6;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
